// File: rtl/hilbert_frame_io.sv
// Frame sequencer/capture buffer: feeds N samples to the core, captures N results on RDY rise, drains over valid/ready.
// Latency GO->first OUT_VALID = N+1+core latency+N; drain stalls without loss while OUT_READY=0; ED=0 freezes everything.
module hilbert_frame_io #(
  parameter int TOTAL_BITS = 32,
  parameter int LOG2N      = 5,
  parameter int MAX_LAT    = 1024,
  parameter int LAT_W      = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ED,
  input  logic                  GO,
  input  logic                  CONT,
  output logic [LOG2N-1:0]      ADDR,
  input  logic [TOTAL_BITS-1:0] DIN_RE,
  input  logic [TOTAL_BITS-1:0] DIN_IM,
  output logic                  START,
  output logic [TOTAL_BITS-1:0] DREAL,
  output logic [TOTAL_BITS-1:0] DIMAG,
  input  logic [TOTAL_BITS-1:0] DOREAL,
  input  logic [TOTAL_BITS-1:0] DOIMAG,
  input  logic                  RDY,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [TOTAL_BITS-1:0] OUT_RE,
  output logic [TOTAL_BITS-1:0] OUT_IM,
  output logic                  OUT_LAST,
  output logic                  BUSY,
  output logic                  TIMEOUT,
  output logic                  OVERRUN
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(N - 1);
  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(MAX_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [LAT_W-1:0]            lat_cnt;
  logic [LOG2N-1:0]            cap_idx;
  logic [LOG2N-1:0]            rd_idx;
  logic                        rdy_q;
  logic                        rdy_rise;
  logic                        accept;
  logic                        wr_en;
  logic [LOG2N-1:0]            wr_idx;
  logic [2*TOTAL_BITS-1:0]     mem [N];

  assign rdy_rise = RDY & ~rdy_q;
  // Transfers only complete on enabled cycles so ED=0 freezes the drain too.
  assign accept   = ED & OUT_VALID & OUT_READY;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else if (ED) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (GO) state_nxt = S_FEED;
      S_FEED:    if (ADDR == LAST_IDX) state_nxt = S_WAIT;
      S_WAIT: begin
        if (rdy_rise) state_nxt = S_CAPTURE;
        else if (lat_cnt == LAT_LIMIT) state_nxt = S_IDLE;
      end
      S_CAPTURE: if (cap_idx == LAST_IDX) state_nxt = S_DRAIN;
      S_DRAIN:   if (accept && rd_idx == LAST_IDX) state_nxt = CONT ? S_FEED : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ADDR    <= '0;
      START   <= 1'b0;
      DREAL   <= '0;
      DIMAG   <= '0;
      TIMEOUT <= 1'b0;
      OVERRUN <= 1'b0;
      rdy_q   <= 1'b0;
      lat_cnt <= '0;
      cap_idx <= '0;
      rd_idx  <= '0;
    end else if (ED) begin
      rdy_q <= RDY;
      START <= (state == S_FEED) && (ADDR == '0);
      if (state == S_FEED) begin
        DREAL <= DIN_RE;
        DIMAG <= DIN_IM;
        // ADDR parks on N-1 so it holds its last value through WAIT.
        if (ADDR != LAST_IDX) ADDR <= ADDR + LOG2N'(1);
      end
      if (state != S_FEED && state_nxt == S_FEED) ADDR <= '0;
      if (state == S_WAIT) lat_cnt <= lat_cnt + LAT_W'(1);
      else lat_cnt <= '0;
      if (state == S_WAIT && !rdy_rise && lat_cnt == LAT_LIMIT) TIMEOUT <= 1'b1;
      if (rdy_rise && state != S_WAIT) OVERRUN <= 1'b1;
      if (state == S_WAIT && rdy_rise) cap_idx <= LOG2N'(1);
      else if (state == S_CAPTURE) cap_idx <= cap_idx + LOG2N'(1);
      if (state == S_CAPTURE) rd_idx <= '0;
      else if (accept) rd_idx <= rd_idx + LOG2N'(1);
    end
  end

  assign wr_en  = ED & ((state == S_WAIT && rdy_rise) || state == S_CAPTURE);
  assign wr_idx = (state == S_WAIT) ? '0 : cap_idx;

  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem[wr_idx] <= {DOIMAG, DOREAL};
  end

  assign BUSY      = (state != S_IDLE);
  assign OUT_VALID = (state == S_DRAIN);
  assign OUT_LAST  = OUT_VALID && (rd_idx == LAST_IDX);
  // Data is zeroed outside DRAIN so stale buffer contents never leak out.
  assign OUT_RE    = OUT_VALID ? mem[rd_idx][TOTAL_BITS-1:0] : '0;
  assign OUT_IM    = OUT_VALID ? mem[rd_idx][2*TOTAL_BITS-1:TOTAL_BITS] : '0;

endmodule

// File: tb/tb_hilbert_frame_io.sv
// Directed bench for hilbert_frame_io: N=32, MAX_LAT=48, source re=k im=-k, core outputs base+i / i.
module tb_hilbert_frame_io;

  logic        CLK;
  logic        RST, ED, GO, CONT, RDY, OUT_READY;
  logic [4:0]  ADDR;
  logic [31:0] DIN_RE, DIN_IM, DREAL, DIMAG, DOREAL, DOIMAG, OUT_RE, OUT_IM;
  logic        START, OUT_VALID, OUT_LAST, BUSY, TIMEOUT, OVERRUN;

  int checks = 0;
  int errors = 0;

  hilbert_frame_io #(.TOTAL_BITS(32), .LOG2N(5), .MAX_LAT(48), .LAT_W(6)) dut (
    .CLK(CLK), .RST(RST), .ED(ED), .GO(GO), .CONT(CONT),
    .ADDR(ADDR), .DIN_RE(DIN_RE), .DIN_IM(DIN_IM),
    .START(START), .DREAL(DREAL), .DIMAG(DIMAG),
    .DOREAL(DOREAL), .DOIMAG(DOIMAG), .RDY(RDY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_RE(OUT_RE), .OUT_IM(OUT_IM), .OUT_LAST(OUT_LAST),
    .BUSY(BUSY), .TIMEOUT(TIMEOUT), .OVERRUN(OVERRUN)
  );

  always_comb begin
    DIN_RE = 32'(ADDR);
    DIN_IM = 32'd0 - 32'(ADDR);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walks FEED from its first cycle (ADDR=0) into the first WAIT cycle.
  task automatic run_feed(input int gap_at, input int rdy_at);
    for (int k = 0; k < 32; k++) begin
      check("feed_addr", 32'(ADDR), k);
      check("feed_start", 32'(START), 32'(k == 1));
      if (k >= 1) begin
        check("feed_dreal", DREAL, k - 1);
        check("feed_dimag", DIMAG, -(k - 1));
      end
      if (k == gap_at) begin
        ED = 1'b0;
        repeat (5) begin
          step();
          check("gap_addr", 32'(ADDR), k);
          check("gap_start", 32'(START), 0);
        end
        ED = 1'b1;
      end
      RDY = (k == rdy_at);
      step();
    end
    RDY = 1'b0;
    check("w1_dreal", DREAL, 31);
    check("w1_dimag", DIMAG, -31);
    check("w1_start", 32'(START), 0);
    check("w1_addr", 32'(ADDR), 31);
    check("w1_busy", 32'(BUSY), 1);
  endtask

  // From the first WAIT cycle: RDY rises in WAIT cycle 'lat', then 32 result samples.
  task automatic run_core(input int lat, input int base);
    repeat (lat - 1) step();
    check("wait_valid", 32'(OUT_VALID), 0);
    check("wait_busy", 32'(BUSY), 1);
    RDY = 1'b1;
    DOREAL = base;
    DOIMAG = 0;
    step();
    for (int i = 1; i < 32; i++) begin
      DOREAL = base + i;
      DOIMAG = i;
      step();
    end
    RDY = 1'b0;
  endtask

  task automatic run_drain(input int base, input bit bp, input bit cont);
    int beat = 0;
    int cyc  = 0;
    int acc  = 0;
    logic rd;
    CONT = cont;
    while (beat < 32 && cyc < 400) begin
      rd = bp ? (cyc % 3 == 0) : 1'b1;
      OUT_READY = rd;
      check("drain_valid", 32'(OUT_VALID), 1);
      check("drain_re", OUT_RE, base + beat);
      check("drain_im", OUT_IM, beat);
      check("drain_last", 32'(OUT_LAST), 32'(beat == 31));
      if (OUT_VALID === 1'b1 && rd) begin
        acc++;
        beat++;
      end
      cyc++;
      step();
    end
    OUT_READY = 1'b0;
    CONT = 1'b0;
    check("drain_accepts", acc, 32);
    check("post_valid", 32'(OUT_VALID), 0);
    check("post_busy", 32'(BUSY), 32'(cont));
    if (cont) check("restart_addr", 32'(ADDR), 0);
  endtask

  initial begin
    int vcount;
    RST = 1'b1; ED = 1'b1; GO = 1'b0; CONT = 1'b0; RDY = 1'b0;
    DOREAL = '0; DOIMAG = '0; OUT_READY = 1'b0;
    repeat (4) step();
    check("rst_addr", 32'(ADDR), 0);
    check("rst_start", 32'(START), 0);
    check("rst_dreal", DREAL, 0);
    check("rst_dimag", DIMAG, 0);
    check("rst_valid", 32'(OUT_VALID), 0);
    check("rst_last", 32'(OUT_LAST), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_timeout", 32'(TIMEOUT), 0);
    check("rst_overrun", 32'(OVERRUN), 0);
    RST = 1'b0;
    step();
    check("idle_busy", 32'(BUSY), 0);

    // Frame 0 with drain backpressure and CONT, then frame 1 with an ED gap.
    GO = 1'b1;
    step();
    GO = 1'b0;
    check("go_busy", 32'(BUSY), 1);
    run_feed(-1, -1);
    run_core(40, 100);
    run_drain(100, 1'b1, 1'b1);
    run_feed(10, -1);
    run_core(40, 200);
    run_drain(200, 1'b0, 1'b0);
    check("f1_overrun", 32'(OVERRUN), 0);
    check("f1_timeout", 32'(TIMEOUT), 0);

    // Core never answers: timeout after 48 WAIT cycles.
    GO = 1'b1;
    step();
    GO = 1'b0;
    run_feed(-1, -1);
    repeat (47) step();
    check("to_busy_before", 32'(BUSY), 1);
    check("to_flag_before", 32'(TIMEOUT), 0);
    step();
    check("to_busy_after", 32'(BUSY), 0);
    check("to_flag_after", 32'(TIMEOUT), 1);
    GO = 1'b1;
    step();
    GO = 1'b0;
    run_feed(-1, -1);
    run_core(40, 300);
    run_drain(300, 1'b0, 1'b0);
    check("to_sticky", 32'(TIMEOUT), 1);

    // RDY pulse during FEED, then reset in the middle of CAPTURE.
    check("ov_before", 32'(OVERRUN), 0);
    GO = 1'b1;
    step();
    GO = 1'b0;
    run_feed(-1, 5);
    check("ov_after", 32'(OVERRUN), 1);
    repeat (9) step();
    RDY = 1'b1;
    DOREAL = 32'd7;
    DOIMAG = 32'd8;
    repeat (5) step();
    RST = 1'b1;
    step();
    check("mid_addr", 32'(ADDR), 0);
    check("mid_start", 32'(START), 0);
    check("mid_dreal", DREAL, 0);
    check("mid_dimag", DIMAG, 0);
    check("mid_valid", 32'(OUT_VALID), 0);
    check("mid_last", 32'(OUT_LAST), 0);
    check("mid_busy", 32'(BUSY), 0);
    check("mid_timeout", 32'(TIMEOUT), 0);
    check("mid_overrun", 32'(OVERRUN), 0);
    check("mid_re", OUT_RE, 0);
    check("mid_im", OUT_IM, 0);
    RST = 1'b0;
    RDY = 1'b0;
    vcount = 0;
    repeat (80) begin
      step();
      if (OUT_VALID !== 1'b0) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    check("abort_idle", 32'(BUSY), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
